instr_sequencer: RTL and testbench
==================================

// Module: instr_sequencer
// PURPOSE
//  Upstream stage of the microcode unit. Fetches 32-bit instruction words from instruction memory.
//  Latches the IR and presents IR[31:26] as opcode. Issues a one-cycle registered sos pulse,
//  then waits for the microcode unit's eos before advancing the PC (pc+4 or branch target).
//  Stops on the halt opcode; an eos watchdog flags a hung segment.
// PARAMETERS
//  ADDR_WIDTH   32      instruction address width
//  RESET_PC     'h0     PC loaded on reset
//  HALT_OPCODE  6'h3F   opcode that halts sequencing (matches microcode freeze code)
//  EOS_TIMEOUT  255     max cycles in WAIT_EOS before fault; 0 disables watchdog
// PORTS
//  clk            in   1           system clock, rising edge
//  rst_n          in   1           asynchronous, active-low reset
//  imem_req       out  1           fetch request, held until imem_ack
//  imem_addr      out  ADDR_WIDTH  fetch address (= pc), stable while imem_req
//  imem_ack       in   1           one-cycle acknowledge; imem_rdata valid same cycle
//  imem_rdata     in   32          instruction word
//  opcode         out  6           IR[31:26] to microcode unit
//  instr          out  32          latched IR for datapath field extraction
//  sos            out  1           start-of-segment pulse, exactly 1 cycle, registered
//  eos            in   1           end-of-segment from microcode unit
//  branch_taken   in   1           sampled with eos; selects branch_target
//  branch_target  in   ADDR_WIDTH  next PC when branch_taken
//  halted         out  1           sticky; set on HALT_OPCODE
//  fault          out  1           sticky; set on eos timeout
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - pc=RESET_PC, IR=0, opcode=0, all 1-bit outputs 0, state=FETCH on the first post-reset edge.
//  FETCH: imem_req=1, imem_addr=pc.
//   - On imem_ack: IR<=imem_rdata, opcode<=imem_rdata[31:26], imem_req<=0, go DECODE.
//  DECODE (1 cycle):
//   - opcode==HALT_OPCODE -> HALT.
//   - Otherwise -> START.
//  START (1 cycle): sos=1. Next cycle -> WAIT_EOS with sos=0, watchdog cleared.
//  WAIT_EOS:
//   - eos is ignored in the START cycle. Only eos sampled high in WAIT_EOS completes the segment;
//     this tolerates microcode eos staying high through sos.
//   - On eos: pc <= branch_taken ? branch_target : pc+4 (mod 2^ADDR_WIDTH wrap), go FETCH.
//   - Otherwise the watchdog increments; at count==EOS_TIMEOUT -> FAULT.
//  HALT / FAULT: terminal until reset.
//   - imem_req=0, sos=0; halted / fault held at 1.
//   - opcode stays at its last value, so a halt keeps the microcode unit frozen.
//  Stability: opcode and instr change only on imem_ack, and are stable DECODE..WAIT_EOS.
//  Latency: ack -> sos high = 2 cycles; eos -> next imem_req = 1 cycle.
//  Boundaries:
//   - ack outside FETCH: ignored.
//   - ack in the same cycle imem_req first rises: accepted.
//   - pc wraps from max to 0 silently.
//   - branch_target is taken verbatim; misalignment is not checked.
//   - Reset mid-fetch: imem_req drops asynchronously; a late ack after release is ignored until FETCH.
//   - Reset during sos: pulse truncated, no re-issue.
// STRUCTURE
//  Package instr_seq_pkg:
//   - seq_state_t enum {FETCH, DECODE, START, WAIT_EOS, HALT, FAULT}
//   - OPCODE_MSB=31, OPCODE_LSB=26, HALT_OPCODE_DEFAULT=6'h3F, PC_STEP=4
//  Sub-module eos_watchdog:
//   - clear/enable/expired; counter width $clog2(EOS_TIMEOUT+1).
//  Top level: FSM, PC register, IR register, sos flop.
// TESTING
//  1 Reset release with imem_rdata=32'h8C000000 (LW), ack 3 cycles later
//    -> addr 0, opcode 6'h23, sos high 2 cycles after ack for exactly 1 cycle.
//  2 eos high through the START cycle and into WAIT_EOS (1-cycle segment)
//    -> only the WAIT_EOS eos is accepted; next fetch at addr 4, no double sos.
//  3 eos with branch_taken=1, branch_target='h40 -> next imem_addr='h40.
//  4 Fetch word 32'hFC000000 -> halted=1, no sos, imem_req stays 0, opcode holds 6'h3F.
//  5 EOS_TIMEOUT=8, eos held 0 -> fault=1 on the 8th WAIT_EOS cycle; terminal until rst_n.
//  6 rst_n low mid-FETCH with late ack and pc='h1C
//    -> imem_req=0 immediately; pc=RESET_PC after release, first fetch at 0.

Source files
------------

// File: rtl/instr_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// instr_seq_pkg
// Shared types and constants for the instruction sequencer:
//   seq_state_t          - sequencer FSM states
//   OPCODE_MSB/LSB       - opcode field position inside the instruction word
//   HALT_OPCODE_DEFAULT  - opcode that freezes sequencing (microcode freeze code)
//   PC_STEP              - byte increment between sequential instructions
//   opcode_of()          - extracts the opcode field from an instruction word
// ----------------------------------------------------------------------------
package instr_seq_pkg;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        START,
        WAIT_EOS,
        HALT,
        FAULT
    } seq_state_t;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int OPCODE_WIDTH = OPCODE_MSB - OPCODE_LSB + 1;
    localparam logic [OPCODE_WIDTH-1:0] HALT_OPCODE_DEFAULT = 6'h3F;
    localparam int PC_STEP = 4;

    function automatic logic [OPCODE_WIDTH-1:0] opcode_of(input logic [31:0] word);
        return word[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// ----------------------------------------------------------------------------
// instr_sequencer_if
// Bundles the instruction-memory fetch port and the microcode-unit handshake.
//   imem_req/imem_addr      sequencer -> imem   fetch request and address
//   imem_ack/imem_rdata     imem -> sequencer   one-cycle ack with data
//   opcode/instr/sos        sequencer -> ucode  decoded opcode, IR, start pulse
//   eos/branch_taken/
//   branch_target           ucode -> sequencer  segment end and next-PC select
// Modports: master = sequencer side, slave = memory/microcode side.
// ----------------------------------------------------------------------------
interface instr_sequencer_if
    import instr_seq_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
);
    logic                    imem_req;
    logic [ADDR_WIDTH-1:0]   imem_addr;
    logic                    imem_ack;
    logic [31:0]             imem_rdata;
    logic [OPCODE_WIDTH-1:0] opcode;
    logic [31:0]             instr;
    logic                    sos;
    logic                    eos;
    logic                    branch_taken;
    logic [ADDR_WIDTH-1:0]   branch_target;

    modport master (
        output imem_req, imem_addr, opcode, instr, sos,
        input  imem_ack, imem_rdata, eos, branch_taken, branch_target
    );

    modport slave (
        input  imem_req, imem_addr, opcode, instr, sos,
        output imem_ack, imem_rdata, eos, branch_taken, branch_target
    );
endinterface

// File: rtl/instr_sequencer_eos_watchdog.sv
// ----------------------------------------------------------------------------
// eos_watchdog
// Counts cycles spent waiting for end-of-segment.
//   clk, rst_n   clock / asynchronous active-low reset
//   clear        zero the counter (asserted as a segment starts)
//   enable       count this cycle (waiting and no eos)
//   expired      the count reaching EOS_TIMEOUT this cycle would hit the limit;
//                the sequencer only acts on it when it also waits without eos.
// EOS_TIMEOUT = 0 disables the watchdog (expired never asserts).
// ----------------------------------------------------------------------------
module eos_watchdog #(
    parameter int EOS_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = (EOS_TIMEOUT > 0) ? $clog2(EOS_TIMEOUT + 1) : 1;

    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (enable) begin
            count_next = count_reg + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    // Expire one count early: the cycle that would make the count equal
    // EOS_TIMEOUT is the one that moves the sequencer to FAULT.
    generate
        if (EOS_TIMEOUT == 0) begin : g_disabled
            assign expired = 1'b0;
        end else begin : g_enabled
            localparam logic [CW-1:0] LAST = CW'(EOS_TIMEOUT - 1);
            assign expired = (count_reg == LAST);
        end
    endgenerate

endmodule

// File: rtl/instr_sequencer.sv
// ----------------------------------------------------------------------------
// instr_sequencer
// Upstream stage of the microcode unit: fetches an instruction, latches it,
// pulses sos for one cycle, then waits for eos before advancing the PC to
// pc+4 or the branch target. Stops on HALT_OPCODE; an eos watchdog flags a
// hung segment.
//   clk      system clock, rising edge
//   rst_n    asynchronous assert, synchronous release, active low
//   bus      instr_sequencer_if.master (imem fetch port + microcode handshake)
//   halted   sticky, set when HALT_OPCODE is decoded
//   fault    sticky, set on eos watchdog expiry
// ----------------------------------------------------------------------------
module instr_sequencer
    import instr_seq_pkg::*;
#(
    parameter int                       ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0]    RESET_PC    = '0,
    parameter logic [OPCODE_WIDTH-1:0]  HALT_OPCODE = HALT_OPCODE_DEFAULT,
    parameter int                       EOS_TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    instr_sequencer_if.master  bus,
    output logic               halted,
    output logic               fault
);
    seq_state_t              state_reg, state_next;
    logic [ADDR_WIDTH-1:0]   pc_reg, pc_next;
    logic [31:0]             ir_reg, ir_next;
    logic [OPCODE_WIDTH-1:0] opcode_reg, opcode_next;
    logic                    req_reg, req_next;
    logic                    sos_reg, sos_next;
    logic                    wd_clear, wd_enable, wd_expired;
    logic                    fetch_accept;

    eos_watchdog #(
        .EOS_TIMEOUT (EOS_TIMEOUT)
    ) u_eos_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    // An ack only counts while a request is actually outstanding; this drops
    // stray or late acks, including one arriving in the first cycle after
    // reset release before imem_req has risen.
    assign fetch_accept = (state_reg == FETCH) && req_reg && bus.imem_ack;

    always_comb begin
        state_next  = state_reg;
        pc_next     = pc_reg;
        ir_next     = ir_reg;
        opcode_next = opcode_reg;
        wd_clear    = 1'b0;
        wd_enable   = 1'b0;

        case (state_reg)
            FETCH: begin
                if (fetch_accept) begin
                    ir_next     = bus.imem_rdata;
                    opcode_next = opcode_of(bus.imem_rdata);
                    state_next  = DECODE;
                end
            end
            DECODE: begin
                state_next = (opcode_reg == HALT_OPCODE) ? HALT : START;
            end
            START: begin
                // eos is deliberately ignored here so a microcode unit that
                // keeps eos high through sos cannot end the new segment early.
                wd_clear   = 1'b1;
                state_next = WAIT_EOS;
            end
            WAIT_EOS: begin
                if (bus.eos) begin
                    pc_next    = bus.branch_taken ? bus.branch_target
                                                  : pc_reg + ADDR_WIDTH'(PC_STEP);
                    state_next = FETCH;
                end else begin
                    wd_enable = 1'b1;
                    if (wd_expired) begin
                        state_next = FAULT;
                    end
                end
            end
            HALT:    state_next = HALT;
            FAULT:   state_next = FAULT;
            default: state_next = FETCH;
        endcase

        // Registered from the next state so the request rises in the same
        // edge that enters FETCH (eos -> imem_req in one cycle).
        req_next = (state_next == FETCH);
        sos_next = (state_next == START);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= FETCH;
            pc_reg     <= RESET_PC;
            ir_reg     <= '0;
            opcode_reg <= '0;
            req_reg    <= 1'b0;
            sos_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            pc_reg     <= pc_next;
            ir_reg     <= ir_next;
            opcode_reg <= opcode_next;
            req_reg    <= req_next;
            sos_reg    <= sos_next;
        end
    end

    assign bus.imem_req  = req_reg;
    assign bus.imem_addr = pc_reg;
    assign bus.opcode    = opcode_reg;
    assign bus.instr     = ir_reg;
    assign bus.sos       = sos_reg;
    assign halted        = (state_reg == HALT);
    assign fault         = (state_reg == FAULT);

endmodule

// File: tb/tb_instr_sequencer.sv
// ----------------------------------------------------------------------------
// tb_instr_sequencer
// Directed plus randomized bench for instr_sequencer. A small reference model
// tracks the architectural PC and the instruction register; expected values
// come from the fetch / segment rules (next PC = target or PC+4 mod 2^32,
// sos two cycles after ack, fault after EOS_TIMEOUT silent wait cycles).
// ----------------------------------------------------------------------------
module tb_instr_sequencer;
    localparam int AW = 32;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic halted;
    logic fault;

    instr_sequencer_if #(.ADDR_WIDTH(AW)) bus ();

    instr_sequencer #(
        .ADDR_WIDTH  (AW),
        .RESET_PC    (32'h0),
        .HALT_OPCODE (6'h3F),
        .EOS_TIMEOUT (TO)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .halted (halted),
        .fault  (fault)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] model_pc;
    logic [31:0] model_ir;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_req", bus.imem_req, 0);
        tick();
        tick();
        check("rst_req2", bus.imem_req, 0);
        check("rst_sos", bus.sos, 0);
        check("rst_halted", halted, 0);
        check("rst_fault", fault, 0);
        check("rst_opcode", bus.opcode, 0);
        check("rst_instr", bus.instr, 0);
        check("rst_addr", bus.imem_addr, 0);
        rst_n    = 1'b1;
        model_pc = 32'h0;
        model_ir = 32'h0;
        $display("reset released");
    endtask

    // Waits for the request, acks after 'delay' cycles and checks decode.
    // Returns in the START cycle (or the HALT cycle for a halt opcode).
    task automatic fetch(input logic [31:0] word, input int delay);
        int n;
        logic [31:0] addr_seen;
        n = 0;
        while (bus.imem_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("req_timeout", (n < 20) ? 32'd1 : 32'd0, 1);
        check("fetch_addr", bus.imem_addr, model_pc);
        addr_seen = bus.imem_addr;
        for (int i = 0; i < delay; i++) begin
            bus.imem_ack = 1'b0;
            tick();
            check("req_hold", bus.imem_req, 1);
            check("addr_hold", bus.imem_addr, model_pc);
        end
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = word;
        tick();
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = $urandom();
        model_ir = word;
        check("req_drop", bus.imem_req, 0);
        check("opcode", {26'd0, bus.opcode}, {26'd0, model_ir[31:26]});
        check("instr", bus.instr, model_ir);
        check("sos_decode", bus.sos, 0);
        tick();
        if (model_ir[31:26] == 6'h3F) begin
            check("halted", halted, 1);
            check("halt_sos", bus.sos, 0);
            check("halt_req", bus.imem_req, 0);
        end else begin
            check("sos_pulse", bus.sos, 1);
            check("not_halted", halted, 0);
        end
        $display("fetch addr=%08h word=%08h delay=%0d", addr_seen, word, delay);
    endtask

    // Called in the START cycle. WAIT_EOS lasts 'len' cycles, eos in the last.
    task automatic segment(input int len, input bit early, input bit br,
                           input logic [31:0] tgt, input bit stray);
        bus.eos          = early;
        bus.branch_taken = 1'($urandom_range(0, 1));
        tick();
        check("sos_one_cycle", bus.sos, 0);
        for (int k = 1; k < len; k++) begin
            bus.eos = 1'b0;
            if (stray) begin
                bus.imem_ack   = 1'b1;
                bus.imem_rdata = $urandom();
            end
            check("wait_instr", bus.instr, model_ir);
            check("wait_req", bus.imem_req, 0);
            check("wait_sos", bus.sos, 0);
            tick();
            bus.imem_ack = 1'b0;
        end
        bus.eos           = 1'b1;
        bus.branch_taken  = br;
        bus.branch_target = tgt;
        tick();
        bus.eos          = 1'b0;
        bus.branch_taken = 1'b0;
        model_pc = br ? tgt : model_pc + 32'd4;
        check("next_req", bus.imem_req, 1);
        check("next_addr", bus.imem_addr, model_pc);
        check("next_sos", bus.sos, 0);
        check("seg_instr", bus.instr, model_ir);
        $display("segment len=%0d early=%0d br=%0d next_pc=%08h", len, early, br, model_pc);
    endtask

    initial begin
        logic [31:0] w;
        logic [31:0] t;
        bus.imem_ack      = 1'b0;
        bus.imem_rdata    = 32'h0;
        bus.eos           = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = 32'h0;
        rst_n = 1'b1;
        #2;
        do_reset();

        // LW fetch, ack a few cycles after release, one-cycle segment with
        // eos held high through START.
        bus.imem_rdata = 32'h8C000000;
        fetch(32'h8C000000, 2);
        check("lw_opcode", {26'd0, bus.opcode}, 32'h23);
        segment(1, 1'b1, 1'b0, 32'h0, 1'b0);

        // Branch to 0x40, then branch to the top of memory and wrap to 0.
        fetch(32'h20010005, 0);
        segment(3, 1'b0, 1'b1, 32'h40, 1'b1);
        fetch(32'h00221820, 1);
        segment(2, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        fetch(32'hAC030008, 0);
        segment(2, 1'b1, 1'b0, 32'h0, 1'b0);
        check("wrap_addr", bus.imem_addr, 32'h0);

        // Randomized segments.
        for (int i = 0; i < 25; i++) begin
            w = $urandom();
            if (w[31:26] == 6'h3F) w[31] = 1'b0;
            t = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : $urandom();
            fetch(w, $urandom_range(0, 3));
            segment($urandom_range(1, 6), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), t, 1'($urandom_range(0, 1)));
        end

        // Watchdog: eos never arrives.
        fetch(32'h10000000, 0);
        bus.eos = 1'b0;
        tick();
        for (int i = 1; i <= TO; i++) begin
            check("fault_early", fault, 0);
            tick();
        end
        check("fault_set", fault, 1);
        for (int i = 0; i < 4; i++) begin
            bus.eos      = 1'b1;
            bus.imem_ack = 1'b1;
            tick();
            check("fault_sticky", fault, 1);
            check("fault_req", bus.imem_req, 0);
            check("fault_sos", bus.sos, 0);
        end
        bus.eos      = 1'b0;
        bus.imem_ack = 1'b0;
        $display("watchdog fault after %0d wait cycles", TO);
        do_reset();

        // Reset mid-fetch at pc 0x1C with a late ack across release.
        fetch(32'h04000000, 0);
        segment(2, 1'b0, 1'b1, 32'h1C, 1'b0);
        #2;
        rst_n          = 1'b0;
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'h8C000000;
        #1;
        check("async_req_drop", bus.imem_req, 0);
        tick();
        rst_n = 1'b1;
        tick();
        bus.imem_ack = 1'b0;
        model_pc = 32'h0;
        model_ir = 32'h0;
        check("late_ack_instr", bus.instr, 0);
        check("late_ack_req", bus.imem_req, 1);
        check("post_rst_addr", bus.imem_addr, 32'h0);
        $display("reset mid-fetch, refetch from 0");

        // Reset during sos truncates the pulse.
        fetch(32'h08000000, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("sos_truncated", bus.sos, 0);
        tick();
        rst_n = 1'b1;
        model_pc = 32'h0;
        tick();
        check("no_reissue_sos", bus.sos, 0);
        $display("reset during sos");

        // Halt opcode freezes everything.
        fetch(32'hFC000000, 1);
        for (int i = 0; i < 5; i++) begin
            bus.imem_ack = 1'b1;
            bus.eos      = 1'($urandom_range(0, 1));
            tick();
            check("halt_sticky", halted, 1);
            check("halt_req_hold", bus.imem_req, 0);
            check("halt_sos_hold", bus.sos, 0);
            check("halt_opcode", {26'd0, bus.opcode}, 32'h3F);
        end
        bus.imem_ack = 1'b0;
        bus.eos      = 1'b0;
        $display("halted");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
